// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: grant-state encoding,
// owner identifiers and the line-terminator character.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MON  = 2'd1,
        ARB_CPU  = 2'd2
    } arb_state_t;

    localparam logic [7:0] LF_CHAR = 8'h0A;

    localparam logic OWN_MON = 1'b0;
    localparam logic OWN_CPU = 1'b1;

    // Grant state that corresponds to an owner id.
    function automatic arb_state_t state_of(input logic owner);
        return (owner == OWN_CPU) ? ARB_CPU : ARB_MON;
    endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// Small circular-buffer character queue for one requester.
// Pushes while full are discarded; full/empty decode the registered count.
module uart_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // full is taken from the pre-edge count, so a push into a full queue is
    // dropped even when a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign level = count;

    // Character storage write.
    // NOTE: storage is deliberately not reset; count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port between the monitor sender and the CPU
// I/O port. Ownership is granted per text line (LF ends a line) with a
// timeout for owners that go quiet mid-line.
// Optional build macro: UART_ARB_DROP_CNT_EN enables the dropped-CPU-push counter.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LOCK_TMO = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mon_char,
    input  logic       mon_en,
    output logic       mon_full,
    input  logic [7:0] cpu_char,
    input  logic       cpu_we,
    output logic       cpu_full,
    output logic [7:0] tx_wdata,
    output logic       tx_wten,
    input  logic       tx_fifo_full,
    output logic [7:0] cpu_drop_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LOCK_TMO + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last_owner;
    logic          last_owner_nxt;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_cnt_nxt;

    logic [7:0]    mon_head;
    logic [7:0]    cpu_head;
    logic          mon_empty;
    logic          cpu_empty;
    logic [LW-1:0] mon_level;
    logic [LW-1:0] cpu_level;

    logic [7:0]    own_head;
    logic          own_empty;
    logic [LW-1:0] own_level;
    logic          other_empty;
    logic          pop_mon;
    logic          pop_cpu;
    logic          lf_pop;
    logic          tmo;
    logic          release_grant;
    logic          own_left;

    uart_arb_fifo #(.DEPTH(DEPTH)) u_mon_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mon_en),
        .push_data (mon_char),
        .pop       (pop_mon),
        .head      (mon_head),
        .full      (mon_full),
        .empty     (mon_empty),
        .level     (mon_level)
    );

    uart_arb_fifo #(.DEPTH(DEPTH)) u_cpu_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cpu_we),
        .push_data (cpu_char),
        .pop       (pop_cpu),
        .head      (cpu_head),
        .full      (cpu_full),
        .empty     (cpu_empty),
        .level     (cpu_level)
    );

    // Select the current owner's queue view; IDLE presents an empty queue and 8'h00.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        own_head    = 8'h00;
        own_empty   = 1'b1;
        own_level   = '0;
        other_empty = 1'b1;
        case (state)
            ARB_MON: begin
                own_head    = mon_head;
                own_empty   = mon_empty;
                own_level   = mon_level;
                other_empty = cpu_empty;
            end
            ARB_CPU: begin
                own_head    = cpu_head;
                own_empty   = cpu_empty;
                own_level   = cpu_level;
                other_empty = mon_empty;
            end
            default: ;
        endcase
    end

    // Write port is driven from registered state and tx_fifo_full only.
    assign tx_wten  = (state != ARB_IDLE) & ~own_empty & ~tx_fifo_full;
    assign tx_wdata = own_head;
    assign pop_mon  = tx_wten & (state == ARB_MON);
    assign pop_cpu  = tx_wten & (state == ARB_CPU);

    // A line ends when LF leaves the owner queue; a quiet owner times out.
    assign lf_pop        = tx_wten & (own_head == LF_CHAR);
    assign tmo           = (idle_cnt == IW'(LOCK_TMO));
    assign release_grant = lf_pop | tmo;
    // Owner still has characters after this cycle's pop (pushes not yet visible).
    assign own_left      = ~own_empty & ~(tx_wten & (own_level == LW'(1)));

    // Grant FSM next state, last-owner tracking and idle counter.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        idle_cnt_nxt   = idle_cnt;

        case (state)
            ARB_IDLE: begin
                if (!mon_empty && !cpu_empty) begin
                    state_nxt = (last_owner == OWN_CPU) ? ARB_MON : ARB_CPU;
                end else if (!mon_empty) begin
                    state_nxt = ARB_MON;
                end else if (!cpu_empty) begin
                    state_nxt = ARB_CPU;
                end
            end
            ARB_MON, ARB_CPU: begin
                if (release_grant) begin
                    if (!other_empty) begin
                        state_nxt = (state == ARB_MON) ? ARB_CPU : ARB_MON;
                    end else if (own_left) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase

        if (state_nxt == state_of(OWN_MON)) begin
            last_owner_nxt = OWN_MON;
        end else if (state_nxt == state_of(OWN_CPU)) begin
            last_owner_nxt = OWN_CPU;
        end

        // Stalled cycles with data pending do not count toward the timeout.
        if ((state == ARB_IDLE) || (state_nxt != state) || tx_wten) begin
            idle_cnt_nxt = '0;
        end else if (own_empty && !tmo) begin
            idle_cnt_nxt = idle_cnt + IW'(1);
        end
    end

    // Grant state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_owner <= OWN_CPU;
            idle_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            idle_cnt   <= idle_cnt_nxt;
        end
    end

`ifdef UART_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Count CPU pushes refused because the CPU queue was full; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (cpu_we && cpu_full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign cpu_drop_cnt = drop_cnt;
`else
    assign cpu_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic, checked by a queue-based reference model and a scoreboard monitor.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int LOCK_TMO = 64;
`ifdef UART_ARB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mon_char = 8'h00;
    logic       mon_en = 1'b0;
    logic       mon_full;
    logic [7:0] cpu_char = 8'h00;
    logic       cpu_we = 1'b0;
    logic       cpu_full;
    logic [7:0] tx_wdata;
    logic       tx_wten;
    logic       tx_fifo_full = 1'b0;
    logic [7:0] cpu_drop_cnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(DEPTH), .LOCK_TMO(LOCK_TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mon_char     (mon_char),
        .mon_en       (mon_en),
        .mon_full     (mon_full),
        .cpu_char     (cpu_char),
        .cpu_we       (cpu_we),
        .cpu_full     (cpu_full),
        .tx_wdata     (tx_wdata),
        .tx_wten      (tx_wten),
        .tx_fifo_full (tx_fifo_full),
        .cpu_drop_cnt (cpu_drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queues of characters plus owner / timeout bookkeeping.
    bit [7:0] mq[$];
    bit [7:0] cq[$];
    int       m_owner;   // 0 none, 1 monitor, 2 cpu
    int       m_last;
    int       m_idle;
    int       m_drop;
    bit [7:0] exp_q[$];
    bit [7:0] cap_q[$];
    bit       exp_wten;
    bit       exp_mon_full;
    bit       exp_cpu_full;
    bit [7:0] exp_drop;
    bit       mon_active = 1'b0;

    task automatic model_reset();
        mq.delete();
        cq.delete();
        exp_q.delete();
        m_owner = 0;
        m_last = 2;
        m_idle = 0;
        m_drop = 0;
        exp_wten = 1'b0;
        exp_mon_full = 1'b0;
        exp_cpu_full = 1'b0;
        exp_drop = 8'h00;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int       own_sz;
        int       oth_sz;
        int       nxt;
        bit       w;
        bit [7:0] ch;
        own_sz = (m_owner == 1) ? mq.size() : (m_owner == 2) ? cq.size() : 0;
        oth_sz = (m_owner == 1) ? cq.size() : (m_owner == 2) ? mq.size() : 0;
        w  = (m_owner != 0) && (own_sz > 0) && !tx_fifo_full;
        ch = 8'h00;
        if (w) ch = (m_owner == 1) ? mq[0] : cq[0];
        exp_wten     = w;
        exp_mon_full = (mq.size() == DEPTH);
        exp_cpu_full = (cq.size() == DEPTH);
        exp_drop     = 8'(m_drop);
        if (w) exp_q.push_back(ch);

        if (m_owner == 0) begin
            if (mq.size() > 0 && cq.size() > 0) nxt = (m_last == 2) ? 1 : 2;
            else if (mq.size() > 0)             nxt = 1;
            else if (cq.size() > 0)             nxt = 2;
            else                                nxt = 0;
        end else if ((w && ch == 8'h0A) || m_idle >= LOCK_TMO) begin
            if (oth_sz > 0)               nxt = 3 - m_owner;
            else if (own_sz - int'(w) > 0) nxt = m_owner;
            else                          nxt = 0;
        end else begin
            nxt = m_owner;
        end

        if (nxt == 0 || nxt != m_owner || w) m_idle = 0;
        else if (own_sz == 0 && m_idle < LOCK_TMO) m_idle++;

        if (w) begin
            if (m_owner == 1) void'(mq.pop_front());
            else              void'(cq.pop_front());
        end
        if (DROP_EN && cpu_we && exp_cpu_full && m_drop < 255) m_drop++;
        if (mon_en && !exp_mon_full) mq.push_back(mon_char);
        if (cpu_we && !exp_cpu_full) cq.push_back(cpu_char);
        if (nxt != 0) m_last = nxt;
        m_owner = nxt;
    endtask

    // Scoreboard monitor: samples on the falling edge, pops expectations on writes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_active) begin
                check("wten", tx_wten, exp_wten);
                check("mon_full", mon_full, exp_mon_full);
                check("cpu_full", cpu_full, exp_cpu_full);
                check("drop_cnt", cpu_drop_cnt, exp_drop);
                if (tx_wten === 1'b1) begin
                    cap_q.push_back(tx_wdata);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got write %0h expected none", tx_wdata);
                    end else begin
                        check("sb_data", tx_wdata, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit me, input bit [7:0] mc, input bit cw, input bit [7:0] cc);
        mon_en   = me;
        mon_char = mc;
        cpu_we   = cw;
        cpu_char = cc;
        tick();
        mon_en = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mon_en = 1'b0;
        cpu_we = 1'b0;
        tx_fifo_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap_q.delete();
        mon_active = 1'b1;
    endtask

    task automatic check_seq(input string name, input bit [7:0] e [8], input int n);
        check({name, "_len"}, cap_q.size(), n);
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            check($sformatf("%s_%0d", name, i), cap_q[i], e[i]);
        end
    endtask

    initial begin
        bit [7:0] rc;
        do_reset();

        // Reset state.
        check("rst_wten", tx_wten, 0);
        check("rst_wdata", tx_wdata, 8'h00);
        check("rst_mon_full", mon_full, 0);
        check("rst_cpu_full", cpu_full, 0);
        check("rst_drop", cpu_drop_cnt, 0);
        check("rst_state", dut.state, ARB_IDLE);
        check("rst_last", dut.last_owner, OWN_CPU);

        // Single monitor char: grant from IDLE, then timeout release.
        cyc(1, 8'h41, 0, 8'h00);
        check("t1_c1_wten", tx_wten, 0);
        idle(1);
        check("t1_c2_wten", tx_wten, 1);
        check("t1_c2_wdata", tx_wdata, 8'h41);
        check("t1_c2_state", dut.state, ARB_MON);
        idle(65);
        check("t1_c67_state", dut.state, ARB_MON);
        idle(1);
        check("t1_c68_state", dut.state, ARB_IDLE);

        // Interleaved lines never mix.
        do_reset();
        cyc(1, 8'h41, 1, 8'h78);
        cyc(1, 8'h42, 1, 8'h79);
        cyc(1, 8'h0A, 1, 8'h0A);
        idle(15);
        check_seq("ilv", '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A, 8'h00, 8'h00}, 6);
        check("ilv_state", dut.state, ARB_IDLE);

        // Round robin between two pending requesters.
        do_reset();
        cyc(1, 8'h4D, 1, 8'h63);
        cyc(1, 8'h0A, 1, 8'h0A);
        cyc(1, 8'h4E, 1, 8'h64);
        cyc(1, 8'h0A, 1, 8'h0A);
        idle(20);
        check_seq("rr", '{8'h4D, 8'h0A, 8'h63, 8'h0A, 8'h4E, 8'h0A, 8'h64, 8'h0A}, 8);

        // TX FIFO stall holds the grant; CPU queue fills meanwhile.
        do_reset();
        tx_fifo_full = 1'b1;
        cyc(1, 8'h50, 0, 8'h00);
        cyc(1, 8'h51, 0, 8'h00);
        cyc(1, 8'h52, 0, 8'h00);
        cyc(0, 8'h00, 1, 8'h63);
        cyc(0, 8'h00, 1, 8'h64);
        cyc(0, 8'h00, 1, 8'h65);
        check("stall_cpu_full3", cpu_full, 0);
        cyc(0, 8'h00, 1, 8'h66);
        check("stall_cpu_full4", cpu_full, 1);
        cyc(0, 8'h00, 1, 8'h67);
        idle(193);
        check("stall_state", dut.state, ARB_MON);
        check("stall_wten", tx_wten, 0);
        tx_fifo_full = 1'b0;
        idle(220);
        check_seq("stall", '{8'h50, 8'h51, 8'h52, 8'h63, 8'h64, 8'h65, 8'h66, 8'h00}, 7);

        // Dropped CPU pushes.
        do_reset();
        tx_fifo_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 8'h39);
        check("drop_10", cpu_drop_cnt, DROP_EN ? 10 : 0);
        for (int i = 0; i < 300; i++) cyc(0, 8'h00, 1, 8'h39);
        check("drop_sat", cpu_drop_cnt, DROP_EN ? 8'hFF : 8'h00);

        // Reset in the middle of a CPU line.
        do_reset();
        tx_fifo_full = 1'b1;
        cyc(0, 8'h00, 1, 8'h73);
        cyc(0, 8'h00, 1, 8'h74);
        check("mid_state_pre", dut.state, ARB_CPU);
        rst_n = 1'b0;
        #1;
        check("mid_wten", tx_wten, 0);
        check("mid_state", dut.state, ARB_IDLE);
        check("mid_last", dut.last_owner, OWN_CPU);
        check("mid_cpu_empty", dut.cpu_empty, 1);
        check("mid_mon_empty", dut.mon_empty, 1);
        @(posedge clk);
        #1;
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tx_fifo_full = ($urandom_range(0, 4) == 0);
            mon_en   = ($urandom_range(0, 2) == 0);
            rc = 8'($urandom);
            mon_char = ($urandom_range(0, 3) == 0) ? 8'h0A : rc;
            cpu_we   = ($urandom_range(0, 2) == 0);
            rc = 8'($urandom);
            cpu_char = ($urandom_range(0, 3) == 0) ? 8'h0A : rc;
            tick();
        end
        mon_en = 1'b0;
        cpu_we = 1'b0;
        tx_fifo_full = 1'b0;
        idle(300);
        check("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
